store_align_buffer: RTL
=======================

STORE_ALIGN_BUFFER -- requirements
Module: store_align_buffer

Interface
REQ-001 Parameter: DEPTH, default 2, number of store-buffer entries (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 st_valid  input  1  store request valid from the MEM stage.
REQ-005 st_op  input  6  instruction opcode bits [31:26].
REQ-006 st_addr  input  32  byte address of the store.
REQ-007 st_data  input  32  register data to store (rt value).
REQ-008 st_ready  output  1  buffer can accept a request this cycle.
REQ-009 mem_req  output  1  write request to data memory.
REQ-010 mem_addr  output  32  word-aligned address, with bits [1:0] = 00.
REQ-011 mem_wdata  output  32  lane-replicated write data.
REQ-012 mem_be  output  4  byte enables; bit i selects bits [8i+7:8i].
REQ-013 mem_ack  input  1  memory accepted the head write this cycle.
REQ-014 ades  output  1  one-cycle pulse: store address error.
REQ-015 ades_addr  output  32  faulting byte address, valid while ades=1.
REQ-016 empty  output  1  no pending stores; the pipeline uses it to order loads.

Function
REQ-017 Recognised ops: SB=101000, SH=101001, SW=101011. A request with any other op SHALL be dropped, with no entry and no ades.
REQ-018 Accept = st_valid & st_ready & recognised op & aligned. st_ready SHALL equal !full and be derived only from registered state.
REQ-019 SB alignment: wdata = {4{st_data[7:0]}}; be = 4'b0001 << st_addr[1:0].
REQ-020 SH alignment: wdata = {2{st_data[15:0]}}; be = st_addr[1] ? 1100 : 0011.
REQ-021 SW alignment: wdata = st_data; be = 1111.
REQ-022 Misalignment is SH with addr[0]=1, or SW with addr[1:0]!=00. In that case, when st_valid & st_ready, the block SHALL write no entry, assert ades for exactly the next cycle, and set ades_addr = st_addr.
REQ-023 Each entry stores {addr[31:2], wdata, be}. Alignment SHALL be computed before the write, so entries are stored already aligned.
REQ-024 FIFO order: mem_req = !empty. mem_addr, mem_wdata and mem_be SHALL reflect the head entry and remain stable until a cycle with mem_ack=1.
REQ-025 Pop occurs when mem_req & mem_ack. If mem_ack=1 while mem_req=0, the block SHALL ignore it.
REQ-026 Latency: a store accepted in cycle N SHALL appear on mem_req no earlier than cycle N+1, and at N+1 exactly if the buffer was empty.
REQ-027 Simultaneous push and pop SHALL leave the occupancy count unchanged. This is only legal when not full.
REQ-028 Pointers SHALL wrap modulo DEPTH. The occupancy counter spans 0..DEPTH. full = (count==DEPTH); empty = (count==0).
REQ-029 When full, st_ready=0 and st_valid SHALL be ignored, with no ades even if misaligned. The requester holds the request.
REQ-030 The memory-side FSM has two states, IDLE (empty) and WRITE (!empty). IDLE->WRITE on push; WRITE->IDLE on a pop that leaves count=0.

Reset
REQ-031 On rst=1 at a clock edge: count=0, pointers=0, mem_req=0, ades=0, ades_addr=0, empty=1, st_ready=1.
REQ-032 Reset mid-operation SHALL discard all pending entries. A mem_ack arriving in the reset cycle SHALL be ignored.
REQ-033 Entry storage contents need no reset. After reset, mem_addr, mem_wdata and mem_be are don't-care while mem_req=0.

Structure
REQ-034 The opcode constants (SB/SH/SW, and LB/LBU/LH/LHU/LW for the load side) SHALL reside in a shared package, together with a store-entry struct typedef {addr_w[29:0], wdata, be}.
REQ-035 One sub-module, store_align, SHALL hold the purely combinational op/addr -> {wdata, be, misaligned, recognised} logic. The FIFO and FSM SHALL stay in the parent module.

Verification
REQ-036 Scenario: SB, addr=0x1003, data=0x000000A5, mem_ack=1. Required: next cycle mem_req=1, mem_addr=0x1000, wdata=0xA5A5A5A5, be=1000, and empty=1 one cycle after the ack.
REQ-037 Scenario: SH, addr=0x2002, data=0x1234BEEF. Required: be=1100, wdata=0xBEEFBEEF. SH at addr=0x2001 instead: ades pulses for one cycle, ades_addr=0x2001, no mem_req.
REQ-038 Scenario: three SWs (0x10, 0x14, 0x18) back-to-back with mem_ack=0 and DEPTH=2. Required: st_ready=0 after two accepts and the third request held. After acks, the writes issue in order 0x10, 0x14, 0x18.
REQ-039 Scenario: full buffer, then push and ack in the same cycle once count=1. Required: count stays 1 and the head advances correctly.
REQ-040 Scenario: two entries pending and rst asserted for one cycle with mem_ack=1. Required: mem_req=0 and empty=1 the next cycle, with no write popped or issued.
REQ-041 Scenario: st_valid with op=100011 (LW), addr=0x3. Required: no entry, no ades, and empty remains 1.

Source files
------------

// File: rtl/store_align_buffer_pkg.sv
// Shared definitions for the store path: MIPS load/store opcodes,
// the aligned store-entry record and the memory-side FSM encodings.
package store_align_buffer_pkg;

    // Store opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    // Load opcodes, used by the load side of the pipeline
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    // Memory-side FSM states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    // One buffered store, already lane-aligned
    typedef struct packed {
        logic [29:0] addr_w;
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_entry_t;

endpackage

// File: rtl/store_align_buffer_align.sv
// Purely combinational store alignment: decodes the opcode, replicates
// the store data across byte lanes and builds the byte-enable mask.
module store_align
    import store_align_buffer_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_data,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic        o_misaligned,
    output logic        o_recognised
);

    // Decode op and derive lane data, byte enables and alignment fault
    always_comb begin
        o_wdata      = 32'h0000_0000;
        o_be         = 4'b0000;
        o_misaligned = 1'b0;
        o_recognised = 1'b0;
        case (i_op)
            OP_SB: begin
                o_recognised = 1'b1;
                o_wdata      = {4{i_data[7:0]}};
                o_be         = 4'b0001 << i_addr_lo;
            end
            OP_SH: begin
                o_recognised = 1'b1;
                o_wdata      = {2{i_data[15:0]}};
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misaligned = i_addr_lo[0];
            end
            OP_SW: begin
                o_recognised = 1'b1;
                o_wdata      = i_data;
                o_be         = 4'b1111;
                o_misaligned = (i_addr_lo != 2'b00);
            end
            default: begin
                o_recognised = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/store_align_buffer.sv
// Store buffer between the MEM stage and data memory. Stores are aligned
// on entry, queued in FIFO order and drained one per mem_ack. Misaligned
// halfword/word stores raise a one-cycle address-error pulse instead.
module store_align_buffer
    import store_align_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [5:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        ades,
    output logic [31:0] ades_addr,
    output logic        empty
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]    CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

    st_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;
    logic [0:0]      r_state;
    logic            r_ades;
    logic [31:0]     r_ades_addr;

    logic [31:0]     w_wdata;
    logic [3:0]      w_be;
    logic            w_misaligned;
    logic            w_recognised;
    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_fault;
    logic [0:0]      w_state_nxt;
    st_entry_t       w_head;

    store_align u_align (
        .i_op         (st_op),
        .i_addr_lo    (st_addr[1:0]),
        .i_data       (st_data),
        .o_wdata      (w_wdata),
        .o_be         (w_be),
        .o_misaligned (w_misaligned),
        .o_recognised (w_recognised)
    );

    // Ready depends only on the registered occupancy, never on inputs
    assign st_ready  = (r_count != CNT_FULL);
    assign empty     = (r_count == {(PW+1){1'b0}});
    assign mem_req   = (r_state == ST_WRITE);
    assign w_fire    = st_valid & st_ready;
    assign w_push    = w_fire & w_recognised & ~w_misaligned;
    assign w_fault   = w_fire & w_recognised & w_misaligned;
    assign w_pop     = mem_req & mem_ack;

    assign w_head    = r_mem[r_rd_ptr];
    assign mem_addr  = {w_head.addr_w, 2'b00};
    assign mem_wdata = w_head.wdata;
    assign mem_be    = w_head.be;
    assign ades      = r_ades;
    assign ades_addr = r_ades_addr;

    // Memory-side FSM: WRITE whenever at least one store is pending
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (w_pop && !w_push && (r_count == CNT_ONE)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Pointers, occupancy, FSM state and address-error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= ST_IDLE;
            r_ades      <= 1'b0;
            r_ades_addr <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_ades  <= w_fault;
            if (w_fault) begin
                r_ades_addr <= st_addr;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= '{addr_w: st_addr[31:2], wdata: w_wdata, be: w_be};
        end
    end

endmodule
